codec_mixer: RTL and testbench
==============================

CODEC_MIXER -- requirements
Module: codec_mixer

Interface
REQ-001 SHALL have parameter WIDTH, default 24, sample width in bits, signed two's complement.
REQ-002 SHALL have parameter NCH, default 2, number of DAC/ADC channels; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, output frame FIFO depth, power of two, at least 2.
REQ-004 SHALL have parameter PITCH_TIMEOUT, default 4800, ADC frames without pitch update before lock is lost.
REQ-005 clk  input  1  sole clock; all logic on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 enabled  input  1  datapath enable.
REQ-008 mode  input  2*NCH  per-channel source: 0 mute, 1 synth, 2 ADC, 3 synth+ADC sum.
REQ-009 synth_in  Axis_If sink  WIDTH  mono synth samples.
REQ-010 adc_sample  Axis_If sink  NCH*WIDTH  ADC frames.
REQ-011 dac_sample  Axis_If source  NCH*WIDTH  mixed DAC frames.
REQ-012 pitch_in  Axis_If sink  WIDTH  detected pitch words.
REQ-013 fundamental  output  WIDTH  held pitch value.
REQ-014 pitch_locked  output  1  high while a pitch update arrived within PITCH_TIMEOUT ADC frames.
REQ-015 dbg_capture, dbg_next  input  1 each; dbg_data  output  WIDTH  debug port.

Function
REQ-016 adc_sample.ready and pitch_in.ready SHALL be constant 1.
REQ-017 Each ADC handshake SHALL overwrite an NCH*WIDTH hold register; frames are formed from its latest value.
REQ-018 synth_in.ready SHALL be enabled AND FIFO not full, derived from registered state only.
REQ-019 Each synth_in handshake SHALL form one frame: per channel mute->0, synth->synth sample, ADC->hold channel, sum->saturating add clipped to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-020 mode SHALL be sampled at the synth_in handshake cycle; changes affect only later frames.
REQ-021 ADC and synth handshakes in the same cycle SHALL use the pre-update hold value.
REQ-022 The formed frame SHALL be written to the FIFO on the cycle after the handshake; into an empty FIFO, dac_sample.valid rises exactly 1 cycle after the handshake.
REQ-023 dac_sample SHALL follow AXIS rules: data stable while valid and not ready; pop on valid AND ready.
REQ-024 Push and pop in the same cycle SHALL leave occupancy unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-025 enabled low SHALL flush the FIFO (occupancy 0, dac_sample.valid 0) in the next cycle and drop any in-flight frame.
REQ-026 A pitch_in handshake SHALL load fundamental, clear the timeout counter and set pitch_locked next cycle.
REQ-027 The timeout counter SHALL increment per ADC handshake, saturate at PITCH_TIMEOUT, and clear pitch_locked on reaching it; fundamental retains its value.
REQ-028 Simultaneous pitch_in and ADC handshakes SHALL give pitch_in priority (counter cleared).

Reset
REQ-029 Reset SHALL clear FIFO, hold register, fundamental, timeout counter, pitch_locked and debug state; dac_sample.valid=0, synth_in.ready=0 in the reset cycle.
REQ-030 Reset asserted mid-operation SHALL discard all queued frames; no partial frame is output afterwards.

Configuration
REQ-031 With macro CODEC_MIXER_DBG_EN defined, a 16-entry buffer SHALL capture channel 0 of the next 16 frames pushed after a dbg_capture rising edge; dbg_next rising edge advances the read pointer, wrapping 15->0; dbg_data shows the entry at the pointer.
REQ-032 Without CODEC_MIXER_DBG_EN, the buffer SHALL be absent, dbg_data tied to 0 and dbg inputs ignored; ports remain.

Verification
REQ-033 mode=2'b01 both channels, synth 0x000100, dac ready=1 -> dac frame {0x000100,0x000100} one cycle after handshake.
REQ-034 mode=3 both channels, ADC ch0=0x7FFFF0, synth 0x000100 -> ch0 output 0x7FFFFF (positive saturation); ADC ch0=0x800010, synth 0xFFFF00 -> 0x800000.
REQ-035 dac ready=0, FIFO_DEPTH=4, 6 synth samples offered -> 4 accepted, synth_in.ready low; release ready -> 4 frames in order, then remaining 2.
REQ-036 Pitch word 0x001234 then 4800 ADC frames with no pitch -> pitch_locked falls after frame 4800, fundamental stays 0x001234.
REQ-037 Reset or enabled low with 3 queued frames -> dac_sample.valid 0 next cycle, no stale frame after recovery.

Source files
------------

// File: rtl/codec_mixer_if.sv
// AXI-Stream style valid/ready channel used for every streaming port of codec_mixer.
// The master drives data/valid and the slave drives ready.
interface Axis_If #(
  parameter int W = 24
) ();
  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/codec_mixer.sv
// Per-channel synth/ADC mixer feeding a small DAC frame FIFO, plus pitch-lock tracking.
// Optional capture buffer for channel 0 is compiled in with `define CODEC_MIXER_DBG_EN.
module codec_mixer #(
  parameter int WIDTH         = 24,
  parameter int NCH           = 2,
  parameter int FIFO_DEPTH    = 4,
  parameter int PITCH_TIMEOUT = 4800
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enabled,
  input  logic [2*NCH-1:0] mode,
  Axis_If.slave            synth_in,
  Axis_If.slave            adc_sample,
  Axis_If.master           dac_sample,
  Axis_If.slave            pitch_in,
  output logic [WIDTH-1:0] fundamental,
  output logic             pitch_locked,
  input  logic             dbg_capture,
  input  logic             dbg_next,
  output logic [WIDTH-1:0] dbg_data
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(PITCH_TIMEOUT + 1);

  logic [NCH*WIDTH-1:0] adc_hold;
  logic [NCH*WIDTH-1:0] frame;
  logic [NCH*WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic                 push;
  logic                 pop;
  logic [TW-1:0]        timeout_cnt;

  function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    if (s[WIDTH] != s[WIDTH-1])
      sat_add = s[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else
      sat_add = s[WIDTH-1:0];
  endfunction

  assign adc_sample.ready = 1'b1;
  assign pitch_in.ready   = 1'b1;

  // Ready depends only on registered occupancy so it never loops back through valid.
  assign synth_in.ready   = enabled && !reset && (count != CW'(FIFO_DEPTH));
  assign dac_sample.valid = !reset && (count != '0);
  assign dac_sample.data  = fifo_mem[rd_ptr];

  assign push = synth_in.valid && synth_in.ready;
  assign pop  = dac_sample.valid && dac_sample.ready;

  always_ff @(posedge clk) begin
    if (reset)
      adc_hold <= '0;
    else if (adc_sample.valid)
      adc_hold <= adc_sample.data;
  end

  // adc_hold is the pre-update value here, so a same-cycle ADC frame lands in later frames only.
  always_comb begin
    frame = '0;
    for (int k = 0; k < NCH; k++) begin
      case (mode[2*k +: 2])
        2'd0:    frame[k*WIDTH +: WIDTH] = '0;
        2'd1:    frame[k*WIDTH +: WIDTH] = synth_in.data;
        2'd2:    frame[k*WIDTH +: WIDTH] = adc_hold[k*WIDTH +: WIDTH];
        default: frame[k*WIDTH +: WIDTH] = sat_add(synth_in.data, adc_hold[k*WIDTH +: WIDTH]);
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr] <= frame;
  end

  always_ff @(posedge clk) begin
    if (reset || !enabled) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A pitch word wins over a same-cycle ADC frame; the counter parks at the timeout value.
  always_ff @(posedge clk) begin
    if (reset) begin
      fundamental  <= '0;
      timeout_cnt  <= '0;
      pitch_locked <= 1'b0;
    end else if (pitch_in.valid) begin
      fundamental  <= pitch_in.data;
      timeout_cnt  <= '0;
      pitch_locked <= 1'b1;
    end else if (adc_sample.valid && (timeout_cnt != TW'(PITCH_TIMEOUT))) begin
      timeout_cnt <= timeout_cnt + 1'b1;
      if (timeout_cnt == TW'(PITCH_TIMEOUT - 1))
        pitch_locked <= 1'b0;
    end
  end

`ifdef CODEC_MIXER_DBG_EN
  logic             capture_q;
  logic             next_q;
  logic [4:0]       cap_left;
  logic [3:0]       cap_wr;
  logic [3:0]       dbg_rd;
  logic [WIDTH-1:0] dbg_buf [16];

  // A capture edge re-arms the buffer for the next 16 pushed frames.
  always_ff @(posedge clk) begin
    if (reset) begin
      capture_q <= 1'b0;
      next_q    <= 1'b0;
      cap_left  <= '0;
      cap_wr    <= '0;
      dbg_rd    <= '0;
      for (int i = 0; i < 16; i++)
        dbg_buf[i] <= '0;
    end else begin
      capture_q <= dbg_capture;
      next_q    <= dbg_next;
      if (dbg_capture && !capture_q) begin
        cap_left <= 5'd16;
        cap_wr   <= '0;
      end else if (push && (cap_left != '0)) begin
        dbg_buf[cap_wr] <= frame[WIDTH-1:0];
        cap_wr          <= cap_wr + 1'b1;
        cap_left        <= cap_left - 1'b1;
      end
      if (dbg_next && !next_q)
        dbg_rd <= dbg_rd + 1'b1;
    end
  end

  assign dbg_data = dbg_buf[dbg_rd];
`else
  logic unused_dbg;
  assign unused_dbg = dbg_capture ^ dbg_next;
  assign dbg_data   = '0;
`endif

endmodule

// File: tb/tb_codec_mixer.sv
// Directed bench for codec_mixer: stimulus pushes hand-computed DAC frames into a
// scoreboard queue, and a negedge monitor pops and compares every DAC handshake.
module tb_codec_mixer;

  localparam int W = 24;
  localparam int N = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             enabled;
  logic [2*N-1:0]   mode;
  logic             dbg_capture;
  logic             dbg_next;
  logic [W-1:0]     fundamental;
  logic             pitch_locked;
  logic [W-1:0]     dbg_data;

  Axis_If #(.W(W))   synth_if ();
  Axis_If #(.W(N*W)) adc_if ();
  Axis_If #(.W(N*W)) dac_if ();
  Axis_If #(.W(W))   pitch_if ();

  logic [N*W-1:0] exp_q [$];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  codec_mixer dut (
    .clk          (clk),
    .reset        (reset),
    .enabled      (enabled),
    .mode         (mode),
    .synth_in     (synth_if),
    .adc_sample   (adc_if),
    .dac_sample   (dac_if),
    .pitch_in     (pitch_if),
    .fundamental  (fundamental),
    .pitch_locked (pitch_locked),
    .dbg_capture  (dbg_capture),
    .dbg_next     (dbg_next),
    .dbg_data     (dbg_data)
  );

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Every DAC handshake must match the oldest outstanding expected frame.
  always @(negedge clk) begin
    if (reset === 1'b0 && dac_if.valid === 1'b1 && dac_if.ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_frame: got 0x%0h, expected no frame", dac_if.data);
      end else begin
        check_output("dac_frame", dac_if.data, exp_q.pop_front());
      end
    end
  end

  // Offer one synth sample; the expected frame is queued once the handshake happens.
  task automatic apply_stimulus(input logic [W-1:0] sample, input logic [N*W-1:0] expected);
    bit accepted = 0;
    synth_if.data  = sample;
    synth_if.valid = 1'b1;
    for (int i = 0; i < 200 && !accepted; i++) begin
      @(negedge clk);
      if (synth_if.ready === 1'b1) begin
        @(posedge clk);
        #1;
        accepted = 1;
      end
    end
    synth_if.valid = 1'b0;
    if (accepted)
      exp_q.push_back(expected);
    else
      check_output("synth_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_adc(input logic [N*W-1:0] frame);
    adc_if.data  = frame;
    adc_if.valid = 1'b1;
    @(posedge clk);
    #1;
    adc_if.valid = 1'b0;
  endtask

  task automatic send_pitch(input logic [W-1:0] word);
    pitch_if.data  = word;
    pitch_if.valid = 1'b1;
    @(posedge clk);
    #1;
    pitch_if.valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++)
      @(posedge clk);
    #1;
    check_output("drain_complete", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset          = 1'b1;
    enabled        = 1'b1;
    mode           = '0;
    dbg_capture    = 1'b0;
    dbg_next       = 1'b0;
    synth_if.valid = 1'b0;
    synth_if.data  = '0;
    adc_if.valid   = 1'b0;
    adc_if.data    = '0;
    pitch_if.valid = 1'b0;
    pitch_if.data  = '0;
    dac_if.ready   = 1'b1;

    // Reset state, sampled while reset is still asserted.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("reset_dac_valid", 64'(dac_if.valid), 64'd0);
    check_output("reset_synth_ready", 64'(synth_if.ready), 64'd0);
    check_output("reset_pitch_locked", 64'(pitch_locked), 64'd0);
    check_output("reset_fundamental", 64'(fundamental), 64'd0);
    check_output("dbg_data_tied_zero", 64'(dbg_data), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_output("ready_after_reset", 64'(synth_if.ready), 64'd1);
    @(posedge clk);
    #1;

    // Both channels from synth; frame must be valid one cycle after the handshake.
    mode = 4'b0101;
    apply_stimulus(24'h000100, {24'h000100, 24'h000100});
    @(negedge clk);
    check_output("latency_one_cycle", 64'(dac_if.valid), 64'd1);
    @(posedge clk);
    #1;

    // Saturating sums in both directions.
    send_adc({24'h000010, 24'h7FFFF0});
    mode = 4'b1111;
    apply_stimulus(24'h000100, {24'h000110, 24'h7FFFFF});
    send_adc({24'h000200, 24'h800010});
    apply_stimulus(24'hFFFF00, {24'h000100, 24'h800000});

    // ch0 synth, ch1 ADC; then ch0 muted, ch1 synth.
    mode = 4'b1001;
    apply_stimulus(24'h000ABC, {24'h000200, 24'h000ABC});
    mode = 4'b0100;
    apply_stimulus(24'h123456, {24'h123456, 24'h000000});

    // Same-cycle ADC and synth: the frame sees the old hold value, the next one the new.
    mode           = 4'b1010;
    adc_if.data    = {24'h111111, 24'h222222};
    adc_if.valid   = 1'b1;
    apply_stimulus(24'h000005, {24'h000200, 24'h800010});
    adc_if.valid   = 1'b0;
    apply_stimulus(24'h000006, {24'h111111, 24'h222222});
    wait_drain();

    // Backpressure: four frames fill the FIFO, the fifth is held off.
    mode         = 4'b0101;
    dac_if.ready = 1'b0;
    for (int i = 1; i <= 4; i++)
      apply_stimulus(24'(i), {24'(i), 24'(i)});
    synth_if.data  = 24'd5;
    synth_if.valid = 1'b1;
    repeat (3) @(negedge clk);
    check_output("ready_low_when_full", 64'(synth_if.ready), 64'd0);
    check_output("head_held_stable", 64'(dac_if.data), 64'({24'd1, 24'd1}));
    @(posedge clk);
    #1;
    dac_if.ready = 1'b1;
    apply_stimulus(24'd5, {24'd5, 24'd5});
    apply_stimulus(24'd6, {24'd6, 24'd6});
    wait_drain();

    // Reset with three queued frames: nothing stale may come out afterwards.
    dac_if.ready = 1'b0;
    for (int i = 7; i <= 9; i++)
      apply_stimulus(24'(i), {24'(i), 24'(i)});
    @(negedge clk);
    check_output("queued_before_reset", 64'(dac_if.valid), 64'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check_output("reset_cycle_dac_valid", 64'(dac_if.valid), 64'd0);
    check_output("reset_cycle_synth_ready", 64'(synth_if.ready), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    reset        = 1'b0;
    dac_if.ready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_output("no_stale_after_reset", 64'(dac_if.valid), 64'd0);
    @(posedge clk);
    #1;
    apply_stimulus(24'h00000A, {24'h00000A, 24'h00000A});
    wait_drain();

    // Enable drop with three queued frames flushes the FIFO.
    dac_if.ready = 1'b0;
    for (int i = 11; i <= 13; i++)
      apply_stimulus(24'(i), {24'(i), 24'(i)});
    @(posedge clk);
    #1;
    enabled = 1'b0;
    @(negedge clk);
    check_output("disabled_synth_ready", 64'(synth_if.ready), 64'd0);
    exp_q.delete();
    @(negedge clk);
    check_output("flush_dac_valid", 64'(dac_if.valid), 64'd0);
    @(posedge clk);
    #1;
    enabled      = 1'b1;
    dac_if.ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    apply_stimulus(24'h00000E, {24'h00000E, 24'h00000E});
    wait_drain();

    // Pitch lock holds for 4799 ADC frames and drops on the 4800th.
    send_pitch(24'h001234);
    @(negedge clk);
    check_output("pitch_locked_set", 64'(pitch_locked), 64'd1);
    check_output("fundamental_loaded", 64'(fundamental), 64'h001234);
    @(posedge clk);
    #1;
    adc_if.data  = {24'h000001, 24'h000002};
    adc_if.valid = 1'b1;
    repeat (4799) @(posedge clk);
    #1;
    adc_if.valid = 1'b0;
    @(negedge clk);
    check_output("locked_after_4799", 64'(pitch_locked), 64'd1);
    @(posedge clk);
    #1;
    send_adc({24'h000001, 24'h000002});
    @(negedge clk);
    check_output("unlocked_after_4800", 64'(pitch_locked), 64'd0);
    check_output("fundamental_retained", 64'(fundamental), 64'h001234);
    @(posedge clk);
    #1;

    // Pitch word and ADC frame together: the counter restarts from zero.
    adc_if.valid   = 1'b1;
    pitch_if.data  = 24'h005678;
    pitch_if.valid = 1'b1;
    @(posedge clk);
    #1;
    pitch_if.valid = 1'b0;
    repeat (4799) @(posedge clk);
    #1;
    adc_if.valid = 1'b0;
    @(negedge clk);
    check_output("priority_relock", 64'(pitch_locked), 64'd1);
    check_output("priority_fundamental", 64'(fundamental), 64'h005678);
    @(posedge clk);
    #1;
    send_adc({24'h000001, 24'h000002});
    @(negedge clk);
    check_output("priority_unlock", 64'(pitch_locked), 64'd0);

    repeat (3) @(posedge clk);
    check_output("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
